memory_controller: RTL

//  Serves the core's single data/memory port: byte-addressed on-chip RAM plus an MMIO window holding
//  a cycle counter and a FIFO-buffered UART transmitter. Sits directly downstream of the core top and

---
 rtl/memory_controller_pkg.sv | 26 ++
 rtl/memory_controller_uart_tx.sv | 85 ++++++++
 rtl/memory_controller.sv | 98 +++++++++
 3 files changed

// File: rtl/memory_controller_pkg.sv
// Shared widths, write-width encodings, MMIO register offsets and UART state type.
package memory_controller_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;
    localparam logic [1:0] WIDTH_RSVD = 2'b11;

    localparam logic [1:0] REG_UART_TX = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CYCLE   = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            WIDTH_WORD: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction
endpackage

// File: rtl/memory_controller_uart_tx.sv
// UART 8N1 transmitter: byte FIFO feeding a bit-timed IDLE/START/DATA/STOP shifter.
// First start bit appears two edges after the push; pushes to a full FIFO are refused.
module uart_tx
    import memory_controller_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    output logic       full_o,
    output logic       busy_o,
    output logic       txd_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    logic [7:0]    fifo_q [DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    uart_state_t   state_q;
    logic [CW-1:0] div_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;
    logic          empty, push_ok, bit_end;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    // Full comes from registered pointers, so a same-edge pop cannot make room for a push.
    assign full_o  = ((wr_ptr_q - rd_ptr_q) == (PW+1)'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign bit_end = (div_cnt_q == CW'(CLK_DIV - 1));
    assign busy_o  = (state_q != IDLE) || !empty;
    assign txd_o   = txd_q;

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            div_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            div_cnt_q <= (state_q == IDLE || bit_end) ? '0 : div_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (!empty) begin
                        shift_q  <= fifo_q[rd_ptr_q[PW-1:0]];
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    txd_q <= 1'b0;
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    txd_q <= shift_q[0];
                    if (bit_end) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    txd_q <= 1'b1;
                    if (bit_end) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/memory_controller.sv
// Data-port memory controller: byte RAM with combinational little-endian reads plus an MMIO
// window holding a UART transmitter, status and a free-running cycle counter.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int MEM_BYTES     = 16384,
    parameter int MMIO_BASE     = 'hF000,
    parameter int CLK_DIV       = 434,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] memory_read_address,
    output logic [DATA_W-1:0] memory_read_data,
    input  logic [1:0]        memory_write_width,
    input  logic [ADDR_W-1:0] memory_write_address,
    input  logic [DATA_W-1:0] memory_write_data,
    input  logic              memory_write_enable,
    output logic              uart_txd
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] MMIO_A = ADDR_W'(MMIO_BASE);

    logic [7:0]        mem [MEM_BYTES];
    logic [DATA_W-1:0] cycle_q, cycle_d;
    logic              overflow_q, overflow_d;
    logic              rd_mmio, wr_mmio, wr_en;
    logic [1:0]        rd_reg, wr_reg;
    logic [2:0]        wr_bytes;
    logic              uart_push, uart_full, uart_busy;

    assign rd_mmio   = (memory_read_address[ADDR_W-1:4] == MMIO_A[ADDR_W-1:4]);
    assign wr_mmio   = (memory_write_address[ADDR_W-1:4] == MMIO_A[ADDR_W-1:4]);
    assign rd_reg    = memory_read_address[3:2];
    assign wr_reg    = memory_write_address[3:2];
    assign wr_en     = memory_write_enable && (memory_write_width != WIDTH_RSVD);
    assign wr_bytes  = width_bytes(memory_write_width);
    assign uart_push = wr_en && wr_mmio && (wr_reg == REG_UART_TX);

    // Each byte lane is range-checked on its own, so words straddling the RAM top read/write partially.
    always_comb begin
        memory_read_data = '0;
        if (rd_mmio) begin
            case (rd_reg)
                REG_STATUS: memory_read_data = {29'b0, overflow_q, uart_full, uart_busy};
                REG_CYCLE:  memory_read_data = cycle_q;
                REG_RSVD:   memory_read_data = '0;
                default:    memory_read_data = '0;
            endcase
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (({1'b0, memory_read_address} + (ADDR_W+1)'(i)) < (ADDR_W+1)'(MEM_BYTES))
                    memory_read_data[8*i +: 8] = mem[AW'(memory_read_address + ADDR_W'(i))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if ((3'(i) < wr_bytes) &&
                    (({1'b0, memory_write_address} + (ADDR_W+1)'(i)) < (ADDR_W+1)'(MEM_BYTES)))
                    mem[AW'(memory_write_address + ADDR_W'(i))] <= memory_write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        overflow_d = overflow_q;
        if (wr_en && wr_mmio && (wr_reg == REG_CYCLE)) cycle_d = memory_write_data;
        if (uart_push && uart_full) overflow_d = 1'b1;
        else if (wr_en && wr_mmio && (wr_reg == REG_STATUS)) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
        end
    end

    uart_tx #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (TX_FIFO_DEPTH)
    ) u_uart_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (uart_push),
        .push_data_i (memory_write_data[7:0]),
        .full_o      (uart_full),
        .busy_o      (uart_busy),
        .txd_o       (uart_txd)
    );
endmodule
